// File: rtl/pump_controller_filtered.sv
// Two-tank pump controller: debounced level inputs, anti short-cycle, run-timeout supervisor
// and a FAULT state with timed recovery. Outputs decode directly from registered state.

module pump_level_filter #(
    parameter int unsigned LVL_W      = 3,
    parameter int unsigned FILTER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LVL_W-1:0] raw_i,
    output logic [LVL_W-1:0] filt_o,
    output logic             valid_o
);
    localparam int unsigned CNT_W = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;

    logic [LVL_W-1:0] cand_q, cand_d;
    logic [LVL_W-1:0] filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    // A new raw value restarts the stability count; the output follows once it has held long enough.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        filt_d  = filt_q;
        valid_d = valid_q;
        if (raw_i != cand_q) begin
            cand_d = raw_i;
            cnt_d  = '0;
        end else if (32'(cnt_q) + 32'd1 < FILTER_CYC) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (32'(cnt_d) + 32'd1 >= FILTER_CYC) begin
            filt_d  = cand_d;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            filt_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            valid_q <= valid_d;
        end
    end

    assign filt_o  = filt_q;
    assign valid_o = valid_q;
endmodule

module pump_controller_filtered #(
    parameter int unsigned CLK_HZ            = 25_000_000,
    parameter int unsigned LVL_W             = 3,
    parameter int unsigned LVL_MAX           = 4,
    parameter int unsigned LVL_SUP_START     = 1,
    parameter int unsigned LVL_INF_START     = 3,
    parameter int unsigned LVL_INF_STOP      = 1,
    parameter int unsigned LVL_SUP_STOP      = 3,
    parameter int unsigned LVL_INF_REFILL    = 4,
    parameter int unsigned INVERT_LEVEL_CODE = 0,
    parameter int unsigned FILTER_MS         = 20,
    parameter int unsigned MIN_OFF_MS        = 5000,
    parameter int unsigned MAX_RUN_MS        = 60000,
    parameter int unsigned FAULT_RECOVERY_MS = 10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_auto,
    input  logic [LVL_W-1:0] lvl_inf,
    input  logic [LVL_W-1:0] lvl_sup,
    output logic             pump_on,
    output logic             solenoid_open,
    output logic             led_green,
    output logic             led_red,
    output logic             fault,
    output logic [1:0]       fault_code
);
    localparam int unsigned CYC_PER_MS  = CLK_HZ / 1000;
    localparam int unsigned FILTER_CYC  = CYC_PER_MS * FILTER_MS;
    localparam int unsigned MIN_OFF_CYC = CYC_PER_MS * MIN_OFF_MS;
    localparam int unsigned MAX_RUN_CYC = CYC_PER_MS * MAX_RUN_MS;
    localparam int unsigned REC_CYC     = CYC_PER_MS * FAULT_RECOVERY_MS;
    localparam int unsigned OFF_W = (MIN_OFF_CYC > 0) ? $clog2(MIN_OFF_CYC + 1) : 1;
    localparam int unsigned RUN_W = (MAX_RUN_CYC > 0) ? $clog2(MAX_RUN_CYC + 1) : 1;
    localparam int unsigned REC_W = (REC_CYC > 0) ? $clog2(REC_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUMPING = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [REC_W-1:0] rec_q, rec_d;
    logic [LVL_W-1:0] sup_prev_q, sup_prev_d;

    logic [LVL_W-1:0] inf_raw_f, sup_raw_f, inf_eff, sup_eff;
    logic             inf_valid, sup_valid, filt_valid;
    logic             invalid_c, start_c, stop_c, sup_rise_c;
    logic             off_done_c, run_done_c, rec_done_c;

    pump_level_filter #(.LVL_W(LVL_W), .FILTER_CYC(FILTER_CYC)) u_filt_inf (
        .clk(clk), .rst_n(rst_n), .raw_i(lvl_inf), .filt_o(inf_raw_f), .valid_o(inf_valid)
    );
    pump_level_filter #(.LVL_W(LVL_W), .FILTER_CYC(FILTER_CYC)) u_filt_sup (
        .clk(clk), .rst_n(rst_n), .raw_i(lvl_sup), .filt_o(sup_raw_f), .valid_o(sup_valid)
    );

    // Validity is judged on the raw sensor code; inversion only applies to in-range codes.
    assign filt_valid = inf_valid & sup_valid;
    assign invalid_c  = (inf_valid && (inf_raw_f > LVL_W'(LVL_MAX)))
                      || (sup_valid && (sup_raw_f > LVL_W'(LVL_MAX)));
    assign inf_eff = (INVERT_LEVEL_CODE != 0) ? LVL_W'(LVL_MAX) - inf_raw_f : inf_raw_f;
    assign sup_eff = (INVERT_LEVEL_CODE != 0) ? LVL_W'(LVL_MAX) - sup_raw_f : sup_raw_f;

    assign start_c    = filt_valid && off_done_c
                      && (sup_eff == LVL_W'(LVL_SUP_START)) && (inf_eff == LVL_W'(LVL_INF_START));
    assign stop_c     = (inf_eff <= LVL_W'(LVL_INF_STOP)) || (sup_eff >= LVL_W'(LVL_SUP_STOP));
    assign sup_rise_c = sup_eff > sup_prev_q;

    // A timer is done on the cycle that completes its configured count.
    assign off_done_c = 32'(off_q) + 32'd1 >= MIN_OFF_CYC;
    assign run_done_c = 32'(run_q) + 32'd1 >= MAX_RUN_CYC;
    assign rec_done_c = 32'(rec_q) + 32'd1 >= REC_CYC;

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        sup_prev_d   = sup_eff;
        off_d        = (32'(off_q) >= MIN_OFF_CYC) ? off_q : off_q + OFF_W'(1);
        run_d        = (32'(run_q) >= MAX_RUN_CYC) ? run_q : run_q + RUN_W'(1);
        rec_d        = (32'(rec_q) >= REC_CYC) ? rec_q : rec_q + REC_W'(1);
        if (!en_auto) begin
            state_d      = ST_IDLE;
            fault_code_d = 2'd0;
        end else if (invalid_c) begin
            state_d = ST_FAULT;
            rec_d   = '0;
            if (state_q != ST_FAULT) fault_code_d = 2'd1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_c) begin
                        state_d = ST_PUMPING;
                        run_d   = '0;
                    end
                end
                ST_PUMPING: begin
                    if (stop_c) begin
                        state_d = ST_IDLE;
                        off_d   = '0;
                    end else if (sup_rise_c) begin
                        run_d = '0;
                    end else if (run_done_c) begin
                        state_d      = ST_FAULT;
                        fault_code_d = 2'd2;
                        rec_d        = '0;
                    end
                end
                ST_FAULT: begin
                    if (rec_done_c) begin
                        state_d      = ST_IDLE;
                        fault_code_d = 2'd0;
                        off_d        = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fault_code_q <= 2'd0;
            off_q        <= OFF_W'(MIN_OFF_CYC);
            run_q        <= '0;
            rec_q        <= '0;
            sup_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            off_q        <= off_d;
            run_q        <= run_d;
            rec_q        <= rec_d;
            sup_prev_q   <= sup_prev_d;
        end
    end

    assign pump_on       = (state_q == ST_PUMPING);
    assign fault         = (state_q == ST_FAULT);
    assign fault_code    = fault_code_q;
    assign led_green     = pump_on;
    assign led_red       = ~pump_on & ~fault;
    assign solenoid_open = filt_valid && (state_q != ST_FAULT) && (inf_eff < LVL_W'(LVL_INF_REFILL));
endmodule

// File: tb/tb_pump_controller_filtered.sv
// Scoreboard bench: the driver queues expected outputs per cycle, the monitor checks them
// on the falling edge. A second instance covers inverted (active-low) level sensors.

module tb_pump_controller_filtered;
    logic       clk = 1'b0;
    logic       rst_n, en_auto;
    logic [2:0] inf, sup, inf2, sup2;
    logic       pump, sol, green, red, flt;
    logic [1:0] code;
    logic       pump2, sol2, green2, red2, flt2;
    logic [1:0] code2;

    typedef struct {
        int unsigned at;
        bit          inv;
        bit          p;
        bit          s;
        bit          f;
        bit [1:0]    c;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pump_controller_filtered #(
        .CLK_HZ(1000), .FILTER_MS(3), .MIN_OFF_MS(5), .MAX_RUN_MS(20), .FAULT_RECOVERY_MS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_auto(en_auto), .lvl_inf(inf), .lvl_sup(sup),
        .pump_on(pump), .solenoid_open(sol), .led_green(green), .led_red(red),
        .fault(flt), .fault_code(code)
    );

    pump_controller_filtered #(
        .CLK_HZ(1000), .FILTER_MS(3), .MIN_OFF_MS(5), .MAX_RUN_MS(20), .FAULT_RECOVERY_MS(8),
        .INVERT_LEVEL_CODE(1)
    ) dut_inv (
        .clk(clk), .rst_n(rst_n), .en_auto(en_auto), .lvl_inf(inf2), .lvl_sup(sup2),
        .pump_on(pump2), .solenoid_open(sol2), .led_green(green2), .led_red(red2),
        .fault(flt2), .fault_code(code2)
    );

    task automatic push(input int unsigned at, input bit inv, input bit p, input bit s,
                        input bit f, input bit [1:0] c, input string nm);
        exp_t e;
        e.at = at; e.inv = inv; e.p = p; e.s = s; e.f = f; e.c = c; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every entry scheduled for this cycle is compared, late entries count as failures.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at <= cyc) begin
                logic [6:0] act, want;
                want = {sb[i].p, sb[i].s, sb[i].p, ~sb[i].p & ~sb[i].f, sb[i].f, sb[i].c};
                act  = sb[i].inv ? {pump2, sol2, green2, red2, flt2, code2}
                                 : {pump, sol, green, red, flt, code};
                total = total + 1;
                if (sb[i].at < cyc) begin
                    bad = bad + 1;
                    $display("FAIL %s: check for cycle %0d never ran (now %0d)", sb[i].nm, sb[i].at, cyc);
                end else if (act !== want) begin
                    bad = bad + 1;
                    $display("FAIL %s @%0d: got pump/sol/grn/red/flt/code=%b want %b",
                             sb[i].nm, cyc, act, want);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int unsigned t, s, p, u, v;
        rst_n = 1'b0; en_auto = 1'b1;
        inf = 3'd3; sup = 3'd1; inf2 = 3'd1; sup2 = 3'd3;
        tick(1);
        push(cyc + 1, 0, 0, 0, 0, 2'd0, "reset");
        push(cyc + 1, 1, 0, 0, 0, 2'd0, "reset_inv");
        tick(2);

        // Start after the filter settles; inverted sensors read raw 1/3 as 3/1.
        rst_n = 1'b1; t = cyc;
        push(t + 2, 0, 0, 0, 0, 2'd0, "pre_valid");
        push(t + 3, 0, 0, 1, 0, 2'd0, "sol_valid");
        push(t + 3, 1, 0, 1, 0, 2'd0, "sol_valid_inv");
        push(t + 4, 0, 1, 1, 0, 2'd0, "start");
        push(t + 4, 1, 1, 1, 0, 2'd0, "start_inv");
        tick(4);

        t = cyc; inf = 3'd1;
        push(t + 3, 0, 1, 1, 0, 2'd0, "glitch_mid");
        push(t + 6, 0, 1, 1, 0, 2'd0, "glitch_end");
        tick(2); inf = 3'd3; tick(4);

        t = cyc; sup = 3'd3;
        push(t + 3, 0, 1, 1, 0, 2'd0, "before_stop");
        push(t + 4, 0, 0, 1, 0, 2'd0, "stop_sup");
        tick(4);

        s = cyc; sup = 3'd1;
        push(s + 4, 0, 0, 1, 0, 2'd0, "min_off_hold");
        push(s + 5, 0, 1, 1, 0, 2'd0, "restart");
        tick(5);

        p = cyc;
        push(p + 19, 0, 1, 1, 0, 2'd0, "run_last");
        push(p + 20, 0, 0, 0, 1, 2'd2, "timeout");
        push(p + 27, 0, 0, 0, 1, 2'd2, "fault_hold");
        push(p + 28, 0, 0, 1, 0, 2'd0, "recover");
        push(p + 32, 0, 0, 1, 0, 2'd0, "off_after_fault");
        push(p + 33, 0, 1, 1, 0, 2'd0, "restart2");
        tick(33);

        t = cyc; inf = 3'd7;
        push(t + 3, 0, 1, 0, 0, 2'd0, "invalid_filt");
        push(t + 4, 0, 0, 0, 1, 2'd1, "invalid");
        push(t + 14, 0, 0, 0, 1, 2'd1, "invalid_hold");
        tick(15); inf = 3'd3;
        push(t + 25, 0, 0, 0, 1, 2'd1, "invalid_clear_wait");
        push(t + 26, 0, 0, 1, 0, 2'd0, "invalid_recover");
        tick(11);

        u = cyc; inf = 3'd7;
        push(u + 4, 0, 0, 0, 1, 2'd1, "refault");
        tick(5); en_auto = 1'b0;
        push(u + 6, 0, 0, 0, 0, 2'd0, "manual_clear");
        tick(1); inf = 3'd3;
        push(u + 12, 0, 0, 1, 0, 2'd0, "manual_idle");
        tick(6); en_auto = 1'b1;
        push(u + 13, 0, 1, 1, 0, 2'd0, "auto_start");
        tick(2);

        rst_n = 1'b0;
        push(u + 15, 0, 0, 0, 0, 2'd0, "reset_mid");
        tick(1); rst_n = 1'b1;
        push(u + 17, 0, 0, 0, 0, 2'd0, "reset_refilter");
        push(u + 18, 0, 0, 1, 0, 2'd0, "post_reset_valid");
        push(u + 19, 0, 1, 1, 0, 2'd0, "post_reset_start");
        tick(4);

        v = cyc; inf = 3'd1;
        push(v + 3, 0, 1, 1, 0, 2'd0, "before_inf_stop");
        push(v + 4, 0, 0, 1, 0, 2'd0, "stop_inf");
        tick(7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
